seg7_countdown_ctrl: RTL

//   Upstream sequencer for the 7-segment driver. On a start pulse it first shows an operation code
//   (T/A/B/C) for a fixed hold time. It then counts down whole seconds from a loaded value (0..15)
//   and shows each digit. Finally it pulses done and blanks the display.
//   Its outputs connect directly to the driver's i_en, i_disp_mode, i_op_code and i_digit_val.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_countdown_ctrl_if.sv | 26 ++
 rtl/ms_tick_gen.sv | 30 +++
 rtl/seg7_countdown_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment countdown sequencer.
package seg7_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHOW_OP = 2'd1,
        ST_COUNT   = 2'd2
    } state_t;

    localparam logic [OP_W-1:0] OP_T = 3'd0;
    localparam logic [OP_W-1:0] OP_A = 3'd1;
    localparam logic [OP_W-1:0] OP_B = 3'd2;
    localparam logic [OP_W-1:0] OP_C = 3'd3;

    localparam logic DISP_OP  = 1'b0;
    localparam logic DISP_NUM = 1'b1;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_countdown_ctrl_if.sv
// Request and display-drive signals between a requester and the countdown sequencer.
interface seg7_countdown_ctrl_if;
    import seg7_pkg::*;

    logic               i_start;
    logic               i_cancel;
    logic [OP_W-1:0]    i_op;
    logic [DIGIT_W-1:0] i_secs;
    logic               o_en;
    logic               o_disp_mode;
    logic [OP_W-1:0]    o_op_code;
    logic [DIGIT_W-1:0] o_digit_val;
    logic               o_busy;
    logic               o_done;

    modport master (
        output i_start, i_cancel, i_op, i_secs,
        input  o_en, o_disp_mode, o_op_code, o_digit_val, o_busy, o_done
    );

    modport slave (
        input  i_start, i_cancel, i_op, i_secs,
        output o_en, o_disp_mode, o_op_code, o_digit_val, o_busy, o_done
    );

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..P-1 and flags the wrap cycle; clr restarts the phase.
module ms_tick_gen #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    import seg7_pkg::*;

    localparam int unsigned P     = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int unsigned CNT_W = cnt_width(P);

    logic [CNT_W-1:0] cnt_q;

    // Decode of the registered count, so the tick lines up with the wrap cycle.
    assign tick = (cnt_q == CNT_W'(P - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_countdown_ctrl.sv
// Sequencer for the 7-segment driver: op code hold, seconds countdown, done pulse.
// Optional digit blinking near the end of the countdown is enabled by defining SEG7_BLINK_EN.
module seg7_countdown_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned OP_HOLD_MS   = 1000,
    parameter int unsigned SEC_MS       = 1000,
    parameter int unsigned BLINK_MS     = 250,
    parameter int unsigned BLINK_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_countdown_ctrl_if.slave  bus
);

    localparam int unsigned MS_MAX_OS = (OP_HOLD_MS > SEC_MS) ? OP_HOLD_MS : SEC_MS;
    localparam int unsigned MS_MAX    = (MS_MAX_OS > BLINK_MS) ? MS_MAX_OS : BLINK_MS;
    localparam int unsigned MS_W      = cnt_width(MS_MAX);

`ifdef SEG7_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    state_t             state_q, state_n;
    logic [MS_W-1:0]    ms_q, ms_n;
    logic [MS_W-1:0]    blink_q, blink_n;
    logic [DIGIT_W-1:0] secs_q, secs_n;
    logic [DIGIT_W-1:0] digit_q, digit_n;
    logic [OP_W-1:0]    op_q, op_n;
    logic               en_q, en_n;
    logic               mode_q, mode_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               clr_c;
    logic               tick_c;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_c),
        .tick  (tick_c)
    );

    // State and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ms_q    <= '0;
            blink_q <= '0;
            secs_q  <= '0;
            digit_q <= '0;
            op_q    <= OP_T;
            en_q    <= 1'b0;
            mode_q  <= DISP_OP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            ms_q    <= ms_n;
            blink_q <= blink_n;
            secs_q  <= secs_n;
            digit_q <= digit_n;
            op_q    <= op_n;
            en_q    <= en_n;
            mode_q  <= mode_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Next-state and next-output logic; cancel overrides everything.
    always_comb begin
        state_n = state_q;
        ms_n    = ms_q;
        blink_n = blink_q;
        secs_n  = secs_q;
        digit_n = digit_q;
        op_n    = op_q;
        en_n    = en_q;
        mode_n  = mode_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        clr_c   = 1'b0;

        if (bus.i_cancel) begin
            state_n = ST_IDLE;
            en_n    = 1'b0;
            busy_n  = 1'b0;
            ms_n    = '0;
            blink_n = '0;
            clr_c   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state_n = ST_SHOW_OP;
                        op_n    = bus.i_op;
                        secs_n  = bus.i_secs;
                        en_n    = 1'b1;
                        mode_n  = DISP_OP;
                        busy_n  = 1'b1;
                        ms_n    = '0;
                        clr_c   = 1'b1;
                    end
                end
                ST_SHOW_OP: begin
                    if (tick_c) begin
                        if (ms_q == MS_W'(OP_HOLD_MS - 1)) begin
                            state_n = ST_COUNT;
                            mode_n  = DISP_NUM;
                            digit_n = secs_q;
                            en_n    = 1'b1;
                            ms_n    = '0;
                            blink_n = '0;
                            clr_c   = 1'b1;
                        end else begin
                            ms_n = ms_q + MS_W'(1);
                        end
                    end
                end
                ST_COUNT: begin
                    if (tick_c) begin
                        if (ms_q == MS_W'(SEC_MS - 1)) begin
                            // Interval over: next digit (blink phase restarts) or finish.
                            ms_n    = '0;
                            blink_n = '0;
                            en_n    = 1'b1;
                            if (digit_q == '0) begin
                                state_n = ST_IDLE;
                                done_n  = 1'b1;
                                en_n    = 1'b0;
                                busy_n  = 1'b0;
                                clr_c   = 1'b1;
                            end else begin
                                digit_n = digit_q - DIGIT_W'(1);
                            end
                        end else begin
                            ms_n = ms_q + MS_W'(1);
                            if (BLINK_EN && (digit_q <= DIGIT_W'(BLINK_THRESH))) begin
                                if (blink_q == MS_W'(BLINK_MS - 1)) begin
                                    blink_n = '0;
                                    en_n    = ~en_q;
                                end else begin
                                    blink_n = blink_q + MS_W'(1);
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    assign bus.o_en        = en_q;
    assign bus.o_disp_mode = mode_q;
    assign bus.o_op_code   = op_q;
    assign bus.o_digit_val = digit_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;

endmodule
